// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the shared UART TX arbiter.
// The slave modport is the arbiter's view; master is the requesters/serializer view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [N_REQ-1:0]   grant;
  logic               locked;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant, locked, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant, locked, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-packet locking in front of a single uart_tx.
// Sequences tx_start/tx_busy and pulses timeout_err if busy never rises.
module uart_tx_arbiter #(
  parameter int N_REQ        = 3,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] win_idx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] cand_s;
  logic [N_REQ-1:0] ready_s;
  logic [7:0]       tx_data_r;
  logic [7:0]       win_data_s;
  logic             locked_r;
  logic             last_r;
  logic             tx_start_r;
  logic             timeout_err_r;
  logic             win_found_s;
  logic             win_last_s;
  logic             accept_s;
  logic             release_s;
  logic             timeout_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  // Eligible requesters and the first of them scanning from rr_ptr
  always_comb begin
    cand_s      = '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    if (locked_r) begin
      cand_s[owner_r] = bus.req_valid[owner_r];
    end else begin
      cand_s = bus.req_valid;
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found_s && cand_s[wrap_idx(rr_ptr_r, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner's byte and last flag, plus the combinational ready handshake
  always_comb begin
    win_data_s = 8'h00;
    win_last_s = 1'b0;
    ready_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        win_data_s = bus.req_data[8*i +: 8];
        win_last_s = bus.req_last[i];
      end else begin
        win_data_s = win_data_s;
      end
    end
    // A busy serializer in IDLE means a foreign user or a frame not yet visible
    accept_s = (state_r == IDLE) && !rst && !bus.tx_busy && win_found_s;
    if (accept_s) begin
      ready_s[win_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    state_s   = state_r;
    release_s = 1'b0;
    timeout_s = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        state_s   = WAIT_BUSY;
        cnt_clr_s = 1'b1;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_s = WAIT_DONE;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
          release_s = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_busy) begin
          state_s = WAIT_DONE;
        end else begin
          state_s   = IDLE;
          release_s = last_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ownership, round-robin pointer, captured byte and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r      <= '0;
      owner_r       <= '0;
      grant_r       <= '0;
      locked_r      <= 1'b0;
      last_r        <= 1'b0;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      cnt_r         <= '0;
    end else begin
      tx_start_r    <= accept_s;
      timeout_err_r <= timeout_s;
      if (accept_s) begin
        tx_data_r <= win_data_s;
        last_r    <= win_last_s;
        owner_r   <= win_idx_s;
        grant_r   <= ready_s;
        locked_r  <= !win_last_s;
      end else if (release_s) begin
        grant_r  <= '0;
        locked_r <= 1'b0;
        rr_ptr_r <= wrap_idx(owner_r, 1);
      end
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.tx_start    = tx_start_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.grant       = grant_r;
  assign bus.locked      = locked_r;
  assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a frame-level reference model checks every
// cycle, and literal expectations pin reset, rotation, locking, timeout and busy cases.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int DW  = 8 * N;
  localparam int TMO = 16;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic chk_en   = 1'b0;
  logic rsp_en   = 1'b0;
  logic rsp_busy = 1'b0;
  logic ext_busy = 1'b0;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   rsp_wait = 0;
  int   rsp_hold = 0;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.tx_busy = rsp_busy | ext_busy;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    for (int i = 0; i < N; i++) begin
      if (i == r) begin
        bus.req_valid[i]       = v;
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]        = l;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      smp();
      if (bus.grant == '0 && !bus.tx_busy && !bus.tx_start) ok = 1'b1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Serializer stand-in: busy rises two cycles after tx_start and stays for 10 cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) rsp_hold = 10;
    end
    if (rsp_hold > 0) begin
      rsp_busy = 1'b1;
      rsp_hold--;
    end else begin
      rsp_busy = 1'b0;
    end
    if (rsp_en && bus.tx_start) rsp_wait = 2;
  end

  // Frame-level reference: owner, lock, pointer and the age of the frame in flight
  int         m_owner  = -1;
  bit         m_locked = 1'b0;
  int         m_rr     = 0;
  bit         m_active = 1'b0;
  int         m_age    = 0;
  bit         m_seen   = 1'b0;
  bit         m_last   = 1'b0;
  logic [7:0] m_data   = 8'h00;
  bit         m_err    = 1'b0;
  int         win;
  logic [N-1:0] exp_ready;
  logic [N-1:0] exp_grant;
  logic [7:0]   sent_q [$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      win = -1;
      if (!rst && !m_active && !bus.tx_busy) begin
        for (int k = 0; k < N; k++) begin
          for (int i = 0; i < N; i++) begin
            if (win < 0 && i == (m_rr + k) % N && bus.req_valid[i] && (!m_locked || i == m_owner))
              win = i;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        exp_ready[i] = (i == win);
        exp_grant[i] = (i == m_owner);
      end
      chk("req_ready",   32'(bus.req_ready),   32'(exp_ready));
      chk("tx_start",    32'(bus.tx_start),    32'(m_active && m_age == 1));
      chk("tx_data",     32'(bus.tx_data),     32'(m_data));
      chk("grant",       32'(bus.grant),       32'(exp_grant));
      chk("locked",      32'(bus.locked),      32'(m_locked));
      chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
      if (bus.tx_start) sent_q.push_back(bus.tx_data);
      m_err = 1'b0;
      if (rst) begin
        m_owner = -1; m_locked = 1'b0; m_rr = 0; m_active = 1'b0;
        m_age = 0; m_seen = 1'b0; m_last = 1'b0; m_data = 8'h00;
      end else if (win >= 0) begin
        m_active = 1'b1; m_age = 1; m_seen = 1'b0; m_owner = win;
        for (int i = 0; i < N; i++) begin
          if (i == win) begin
            m_data = bus.req_data[8*i +: 8];
            m_last = bus.req_last[i];
          end
        end
        m_locked = !m_last;
      end else if (m_active) begin
        if (m_age == 1) begin
          m_age = 2;
        end else if (!m_seen) begin
          if (bus.tx_busy) begin
            m_seen = 1'b1;
          end else if (m_age == 1 + TMO) begin
            m_active = 1'b0; m_err = 1'b1; m_rr = (m_owner + 1) % N;
            m_owner = -1; m_locked = 1'b0;
          end else begin
            m_age++;
          end
        end else if (!bus.tx_busy) begin
          m_active = 1'b0;
          if (m_last) begin
            m_rr = (m_owner + 1) % N; m_owner = -1; m_locked = 1'b0;
          end
        end
      end
    end
  end

  logic [7:0] rr_exp  [6] = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
  logic [7:0] pkt     [3] = '{8'hA1, 8'hA2, 8'hA3};
  logic [7:0] lock_exp[4] = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
  int rr_cnt [N];
  int k_acc, r0, seen;
  bit got;

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    bus.req_valid = N'($urandom);
    bus.req_data  = DW'($urandom);
    bus.req_last  = N'($urandom);
    ext_busy      = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      nxt();
      chk_en = 1'b1;
      bus.req_valid = N'($urandom);
      bus.req_data  = DW'($urandom);
      bus.req_last  = N'($urandom);
      ext_busy      = 1'($urandom);
    end
    smp();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    nxt();
    rst = 1'b0; ext_busy = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    smp();
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);

    // Round-robin with all requesters valid
    rsp_en = 1'b1;
    sent_q.delete();
    for (int i = 0; i < N; i++) rr_cnt[i] = 0;
    nxt();
    set_req(0, 1'b1, 8'h10, 1'b1);
    set_req(1, 1'b1, 8'h20, 1'b1);
    set_req(2, 1'b1, 8'h30, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      smp();
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) rr_cnt[i]++;
      if (sent_q.size() >= 6) got = 1'b1;
      else nxt();
    end
    chk("rr_done", 32'(got), 32'd1);
    nxt();
    bus.req_valid = '0;
    wait_idle("rr_idle");
    for (int i = 0; i < 6; i++)
      chk("rr_byte", 32'(i < sent_q.size() ? sent_q[i] : 8'h00), 32'(rr_exp[i]));
    for (int i = 0; i < N; i++) chk("rr_ready_count", 32'(rr_cnt[i]), 32'd2);

    // Single byte from req0
    nxt();
    set_req(0, 1'b1, 8'h41, 1'b1);
    smp();
    chk("single_ready", 32'(bus.req_ready), 32'b001);
    nxt();
    set_req(0, 1'b0, 8'h00, 1'b0);
    smp();
    chk("single_start", 32'(bus.tx_start), 32'd1);
    chk("single_data", 32'(bus.tx_data), 32'h41);
    chk("single_grant", 32'(bus.grant), 32'b001);
    for (int j = 2; j <= 13; j++) begin
      nxt(); smp();
      chk("single_grant_hold", 32'(bus.grant), 32'b001);
    end
    nxt(); smp();
    chk("single_grant_free", 32'(bus.grant), 32'd0);

    // Packet lock: req1 sends A1..A3 while req0 waits with 0x55
    sent_q.delete();
    k_acc = 0; r0 = 0;
    nxt();
    set_req(1, 1'b1, pkt[0], 1'b0);
    for (int c = 0; c < 300 && k_acc < 3; c++) begin
      smp();
      if (k_acc >= 1) chk("lock_held", 32'(bus.locked), 32'd1);
      if (bus.req_ready[0]) r0++;
      if (bus.req_ready[1]) k_acc++;
      nxt();
      if (k_acc >= 1) set_req(0, 1'b1, 8'h55, 1'b1);
      if (k_acc < 3) set_req(1, 1'b1, pkt[k_acc], k_acc == 2);
      else set_req(1, 1'b0, 8'h00, 1'b0);
    end
    chk("lock_accepts", 32'(k_acc), 32'd3);
    chk("lock_no_req0", 32'(r0), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      smp();
      if (bus.req_ready[0]) got = 1'b1;
      else nxt();
    end
    chk("lock_req0_next", 32'(got), 32'd1);
    nxt();
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_idle("lock_idle");
    chk("lock_sent_count", 32'(sent_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("lock_byte", 32'(i < sent_q.size() ? sent_q[i] : 8'h00), 32'(lock_exp[i]));

    // Busy timeout: serializer never answers req2
    rsp_en = 1'b0;
    nxt();
    set_req(2, 1'b1, 8'h7E, 1'b1);
    smp();
    chk("tmo_ready", 32'(bus.req_ready), 32'b100);
    for (int j = 1; j <= 19; j++) begin
      nxt();
      if (j == 1) set_req(2, 1'b0, 8'h00, 1'b0);
      smp();
      chk("tmo_start", 32'(bus.tx_start), 32'(j == 1));
      chk("tmo_err", 32'(bus.timeout_err), 32'(j == 18));
      chk("tmo_grant", 32'(bus.grant), (j <= 17) ? 32'b100 : 32'd0);
    end
    rsp_en = 1'b1;
    nxt();
    set_req(0, 1'b1, 8'h0A, 1'b1);
    set_req(2, 1'b1, 8'h2A, 1'b1);
    smp();
    chk("tmo_next_winner", 32'(bus.req_ready), 32'b001);
    nxt();
    bus.req_valid = '0;
    wait_idle("tmo_idle");

    // Busy held externally, then reset during a non-last byte
    nxt();
    ext_busy = 1'b1;
    set_req(0, 1'b1, 8'h66, 1'b0);
    for (int j = 0; j < 5; j++) begin
      smp();
      chk("ext_busy_ready", 32'(bus.req_ready), 32'd0);
      chk("ext_busy_start", 32'(bus.tx_start), 32'd0);
      nxt();
    end
    ext_busy = 1'b0;
    smp();
    chk("ext_free_ready", 32'(bus.req_ready), 32'b001);
    nxt();
    set_req(0, 1'b0, 8'h00, 1'b0);
    seen = 0;
    for (int c = 0; c < 40 && seen < 2; c++) begin
      smp();
      if (bus.tx_busy) seen++;
      if (seen < 2) nxt();
    end
    chk("ext_busy_seen", 32'(seen), 32'd2);
    nxt();
    rst = 1'b1;
    smp();
    chk("rst_mid_locked_before", 32'(bus.locked), 32'd1);
    nxt();
    rst = 1'b0;
    smp();
    chk("rst_mid_locked", 32'(bus.locked), 32'd0);
    chk("rst_mid_grant", 32'(bus.grant), 32'd0);
    wait_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
